reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 10 +
 rtl/reg_bank_scoreboard.sv | 72 +++++++
 rtl/reg_bank.sv | 64 ++++++
 tb/tb_reg_bank.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared processor constants: register-file geometry and scoreboard counter
// width, used by decode, register bank and write-back alike.
package reg_bank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_CNT_W  = 2;
  localparam int NREGS      = 2 ** DEF_ADDR_W;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_scoreboard.sv
// Per-register pending-write scoreboard. Issues of a destination register
// count up, write-backs count down; saturating counters with a sticky error
// flag on overflow/underflow. The stall output looks at both read ports and
// treats a write-back landing this cycle as already satisfying one pending
// write. An issue in the current cycle never affects the stall output.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic              stall,
  output logic              err
);

  localparam int NR = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pend [NR];

  logic [CNT_W-1:0] pend_a;
  logic [CNT_W-1:0] pend_b;
  logic             hit_a;
  logic             hit_b;
  logic             stall_a;
  logic             stall_b;

  // Update each counter: increment on issue, decrement on write-back, hold
  // when both target the same register; saturate and flag on over/underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) pend[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        logic is_iss;
        logic is_wr;
        is_iss = issue && (issue_rd == ADDR_W'(r));
        is_wr  = wr_en && (wr_addr == ADDR_W'(r));
        if (is_iss && !is_wr) begin
          if (pend[r] == CNT_MAX) err <= 1'b1;
          else                    pend[r] <= pend[r] + CNT_ONE;
        end else if (is_wr && !is_iss) begin
          if (pend[r] == '0) err <= 1'b1;
          else               pend[r] <= pend[r] - CNT_ONE;
        end
      end
    end
  end

  // Effective pending count per port is nonzero unless at most one write is
  // outstanding and it is being written back right now.
  always_comb begin
    pend_a  = pend[ra];
    pend_b  = pend[rb];
    hit_a   = wr_en && (wr_addr == ra);
    hit_b   = wr_en && (wr_addr == rb);
    stall_a = (pend_a != '0) && !(hit_a && (pend_a == CNT_ONE));
    stall_b = (pend_b != '0) && !(hit_b && (pend_b == CNT_ONE));
    stall   = stall_a || stall_b;
  end

endmodule : reg_scoreboard

// File: rtl/reg_bank.sv
// Register bank: 2**ADDR_W general registers (none hardwired), two
// combinational read ports with write-back bypass, and a pending-write
// scoreboard that raises a stall when an operand is not yet available.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] in_WC,
  input  logic [DATA_W-1:0] in_WPC,
  input  logic              in_W_RB,
  input  logic [ADDR_W-1:0] in_RA,
  input  logic [ADDR_W-1:0] in_RB,
  input  logic              in_issue,
  input  logic [ADDR_W-1:0] in_issue_rd,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic              out_stall,
  output logic              out_err
);

  localparam int NR = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NR];
  logic              wr_live;

  // Store write-back data; reset clears every register immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) regs[r] <= '0;
    end else if (in_W_RB) begin
      regs[in_WC] <= in_WPC;
    end
  end

  // Read ports: a write-back to the addressed register this cycle wins over
  // storage; writes are not forwarded while reset is held.
  always_comb begin
    wr_live = in_W_RB && !rst;
    out_A   = (wr_live && (in_WC == in_RA)) ? in_WPC : regs[in_RA];
    out_B   = (wr_live && (in_WC == in_RB)) ? in_WPC : regs[in_RB];
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (in_W_RB),
    .wr_addr  (in_WC),
    .issue    (in_issue),
    .issue_rd (in_issue_rd),
    .ra       (in_RA),
    .rb       (in_RB),
    .stall    (out_stall),
    .err      (out_err)
  );

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: bypass/storage reads, scoreboard stall,
// saturation and sticky error, and asynchronous reset.
module tb_reg_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  in_WC;
  logic [31:0] in_WPC;
  logic        in_W_RB;
  logic [3:0]  in_RA;
  logic [3:0]  in_RB;
  logic        in_issue;
  logic [3:0]  in_issue_rd;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic        out_stall;
  logic        out_err;

  int n_checks = 0;
  int n_errors = 0;

  reg_bank dut (
    .clk         (clk),
    .rst         (rst),
    .in_WC       (in_WC),
    .in_WPC      (in_WPC),
    .in_W_RB     (in_W_RB),
    .in_RA       (in_RA),
    .in_RB       (in_RB),
    .in_issue    (in_issue),
    .in_issue_rd (in_issue_rd),
    .out_A       (out_A),
    .out_B       (out_B),
    .out_stall   (out_stall),
    .out_err     (out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: apply a full input vector, then let combinational paths settle
  task automatic drive(input logic wb, input logic [3:0] wc, input logic [31:0] wpc,
                       input logic iss, input logic [3:0] rd,
                       input logic [3:0] ra, input logic [3:0] rb);
    in_W_RB = wb; in_WC = wc; in_WPC = wpc;
    in_issue = iss; in_issue_rd = rd;
    in_RA = ra; in_RB = rb;
    #1;
  endtask

  task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, ra, rb);
  endtask

  // advance one rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle(4'd0, 4'd15);
    #1;
    check("reset_a", out_A, 32'h0);
    check("reset_b", out_B, 32'h0);
    check("reset_stall", {31'b0, out_stall}, 32'h0);
    check("reset_err", {31'b0, out_err}, 32'h0);
    step();
    rst = 1'b0;

    // issue r3, then r3 stalls until its write-back arrives
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd0, 4'd0);
    step();
    idle(4'd0, 4'd3);
    check("r3_stall", {31'b0, out_stall}, 32'h1);
    drive(1'b1, 4'd3, 32'h12, 1'b0, 4'd0, 4'd0, 4'd3);
    check("r3_wb_stall", {31'b0, out_stall}, 32'h0);
    check("r3_wb_bypass", out_B, 32'h12);
    step();
    idle(4'd0, 4'd3);
    check("r3_stored", out_B, 32'h12);
    check("r3_nostall", {31'b0, out_stall}, 32'h0);
    check("r3_err", {31'b0, out_err}, 32'h0);

    // r5: bypass in the write cycle, storage afterwards, both ports same reg
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd0, 4'd0);
    step();
    drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd5, 4'd5);
    check("r5_bypass_a", out_A, 32'hDEADBEEF);
    check("r5_bypass_b", out_B, 32'hDEADBEEF);
    check("r5_wb_stall", {31'b0, out_stall}, 32'h0);
    step();
    idle(4'd5, 4'd3);
    check("r5_stored_a", out_A, 32'hDEADBEEF);
    check("r3_kept_b", out_B, 32'h12);
    check("r5_err", {31'b0, out_err}, 32'h0);

    // r9: issue+write same cycle leaves count at 1
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd0, 4'd0);
    step();
    drive(1'b1, 4'd9, 32'h99, 1'b1, 4'd9, 4'd9, 4'd0);
    check("r9_same_stall", {31'b0, out_stall}, 32'h0);
    step();
    idle(4'd9, 4'd9);
    check("r9_still_pend", {31'b0, out_stall}, 32'h1);
    check("r9_data", out_A, 32'h99);
    // different registers in one cycle: retire r9, issue r10
    drive(1'b1, 4'd9, 32'h77, 1'b1, 4'd10, 4'd9, 4'd9);
    check("r9_last_wb_stall", {31'b0, out_stall}, 32'h0);
    step();
    idle(4'd10, 4'd9);
    check("r10_pend", {31'b0, out_stall}, 32'h1);
    idle(4'd9, 4'd9);
    check("r9_clear", {31'b0, out_stall}, 32'h0);
    check("r9_data2", out_A, 32'h77);
    check("r9_err", {31'b0, out_err}, 32'h0);
    drive(1'b1, 4'd10, 32'hA0, 1'b0, 4'd0, 4'd10, 4'd10);
    step();
    idle(4'd10, 4'd10);
    check("r10_clear", {31'b0, out_stall}, 32'h0);
    check("r10_err", {31'b0, out_err}, 32'h0);

    // r7: saturate at 3, fourth issue sets err
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd0);
      check("r7_issue_no_stall_now", {31'b0, out_stall}, (i == 0) ? 32'h0 : 32'h1);
      step();
    end
    idle(4'd7, 4'd7);
    check("r7_three_err", {31'b0, out_err}, 32'h0);
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd0, 4'd0);
    step();
    idle(4'd7, 4'd0);
    check("r7_ovf_err", {31'b0, out_err}, 32'h1);
    check("r7_ovf_stall", {31'b0, out_stall}, 32'h1);
    // three write-backs; only the third retires the last pending write
    drive(1'b1, 4'd7, 32'h71, 1'b0, 4'd0, 4'd7, 4'd0);
    check("r7_wb1_stall", {31'b0, out_stall}, 32'h1);
    step();
    drive(1'b1, 4'd7, 32'h72, 1'b0, 4'd0, 4'd0, 4'd7);
    check("r7_wb2_stall", {31'b0, out_stall}, 32'h1);
    step();
    drive(1'b1, 4'd7, 32'h73, 1'b0, 4'd0, 4'd7, 4'd7);
    check("r7_wb3_stall", {31'b0, out_stall}, 32'h0);
    step();
    idle(4'd7, 4'd0);
    check("r7_done_stall", {31'b0, out_stall}, 32'h0);
    check("r7_data", out_A, 32'h73);
    check("r7_err_sticky", {31'b0, out_err}, 32'h1);

    // asynchronous reset between edges
    drive(1'b1, 4'd1, 32'hA, 1'b0, 4'd0, 4'd0, 4'd0);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd0, 4'd0);
    step();
    idle(4'd1, 4'd4);
    check("pre_rst_r1", out_A, 32'hA);
    check("pre_rst_stall", {31'b0, out_stall}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a", out_A, 32'h0);
    check("async_rst_stall", {31'b0, out_stall}, 32'h0);
    check("async_rst_err", {31'b0, out_err}, 32'h0);
    drive(1'b1, 4'd6, 32'h66, 1'b1, 4'd6, 4'd6, 4'd6);
    check("rst_no_bypass", out_A, 32'h0);
    step();
    idle(4'd6, 4'd6);
    check("rst_write_ignored", out_A, 32'h0);
    rst = 1'b0;
    #1;

    // first edge after reset: underflow write to r2 updates data and sets err
    drive(1'b1, 4'd2, 32'h22, 1'b0, 4'd0, 4'd2, 4'd1);
    check("r2_bypass", out_A, 32'h22);
    check("r2_pre_err", {31'b0, out_err}, 32'h0);
    step();
    idle(4'd2, 4'd1);
    check("r2_stored", out_A, 32'h22);
    check("r1_cleared", out_B, 32'h0);
    check("r2_udf_err", {31'b0, out_err}, 32'h1);
    check("r2_stall", {31'b0, out_stall}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_bank
